// File: rtl/fini_pkg.sv
// fini_pkg: shared constants, FSM state encoding and helpers for the FINI
// multiply-and-correct arbiter.
//   K, N       : default fault tolerance and replica count (N = 2K+1)
//   state_e    : arbiter FSM states
//   majority() : majority vote over the low n bits of a word
//   id_width() : requester index width
package fini_pkg;

  localparam int unsigned K         = 2;
  localparam int unsigned N         = 2 * K + 1;
  localparam int unsigned MAJ_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // 1 iff strictly more than half of the low n bits of p are set
  function automatic logic majority(input logic [MAJ_MAX_W-1:0] p, input int unsigned n);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < MAJ_MAX_W; i++) begin
      if (i < n) ones += 32'(p[i]);
    end
    return (ones >= (n / 2) + 1);
  endfunction

  // Index width for nreq requesters, never narrower than one bit
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fini_and_correct.sv
// fini_and_correct: combinational FINI multiply-and-correct datapath.
//   a, b : replicated-bit operands (N copies each)
//   c    : majority-corrected product codeword (all-0 or all-1)
//   err  : per-replica product was not unanimous
module fini_and_correct
  import fini_pkg::majority;
  import fini_pkg::MAJ_MAX_W;
#(
  parameter int unsigned N = fini_pkg::N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         err
);

  logic [N-1:0] p;
  logic         maj;

  assign p   = a & b;
  assign maj = majority(MAJ_MAX_W'(p), N);
  assign c   = {N{maj}};
  assign err = (p != '0) && (p != '1);

endmodule

// File: rtl/fini_mul_arbiter.sv
// fini_mul_arbiter: round-robin front-end sharing one FINI multiply-and-correct
// datapath between NREQ requesters.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester request handshake (ready is one-hot)
//   req_a, req_b         : operand codewords, requester i at [i*N +: N]
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id, rsp_c        : owning requester and corrected codeword
//   rsp_err              : correction acted on this response
//   err_cnt              : saturating count of corrected responses
module fini_mul_arbiter
  import fini_pkg::state_e;
  import fini_pkg::IDLE;
  import fini_pkg::EXEC;
  import fini_pkg::RESP;
  import fini_pkg::id_width;
#(
  parameter  int unsigned K     = fini_pkg::K,
  parameter  int unsigned NREQ  = 2,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned N     = 2 * K + 1,
  localparam int unsigned ID_W  = id_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [N-1:0]        rsp_c,
  output logic                rsp_err,
  output logic [CNT_W-1:0]    err_cnt
);

  state_e          state, state_n;
  logic [ID_W-1:0] ptr, win, op_id;
  logic            any_valid, grant;
  logic [N-1:0]    win_a, win_b, op_a, op_b, dp_c;
  logic            dp_err;

  // Round-robin pick: first valid requester at or after ptr, wrapping
  always_comb begin
    int unsigned idx;
    win       = ptr;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_valid && req_valid[ID_W'(idx)]) begin
        any_valid = 1'b1;
        win       = ID_W'(idx);
      end
    end
  end

  // Operand select for the current winner
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == ID_W'(i)) begin
        win_a = req_a[i*N +: N];
        win_b = req_b[i*N +: N];
      end
    end
  end

  // Next state and grant; a RESP handshake may re-grant in the same cycle
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant   = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: state_n = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (any_valid) begin
            grant   = 1'b1;
            state_n = EXEC;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // One-hot ready to the winner (combinational from req_valid/rsp_ready)
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (win == ID_W'(i));
    end
  end

  fini_and_correct #(.N(N)) u_dp (
    .a   (op_a),
    .b   (op_b),
    .c   (dp_c),
    .err (dp_err)
  );

  // State, pointer and operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        op_a  <= win_a;
        op_b  <= win_b;
        op_id <= win;
        ptr   <= (32'(win) == NREQ - 1) ? '0 : win + ID_W'(1);
      end
    end
  end

  // Response registers; the fault count is taken when the result is formed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rsp_valid <= (state_n == RESP);
      if (state == EXEC) begin
        rsp_c   <= dp_c;
        rsp_err <= dp_err;
        rsp_id  <= op_id;
        if (dp_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fini_mul_arbiter.sv
// tb_fini_mul_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model. A second instance with a
// 2-bit counter shares all inputs to exercise counter saturation.
module tb_fini_mul_arbiter;

  localparam int unsigned K    = 2;
  localparam int unsigned N    = 5;
  localparam int unsigned NREQ = 2;
  localparam int unsigned ID_W = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_ready_s;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [ID_W-1:0]   rsp_id;
  logic [N-1:0]      rsp_c;
  logic [7:0]        err_cnt;
  logic              rsp_valid_s, rsp_err_s;
  logic [ID_W-1:0]   rsp_id_s;
  logic [N-1:0]      rsp_c_s;
  logic [1:0]        err_cnt_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fini_mul_arbiter #(.K(K), .NREQ(NREQ), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  fini_mul_arbiter #(.K(K), .NREQ(NREQ), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_s), .rsp_c(rsp_c_s), .rsp_err(rsp_err_s), .err_cnt(err_cnt_s)
  );

  // Reference: majority of the per-replica AND
  function automatic logic [N-1:0] ref_c(input logic [N-1:0] a, input logic [N-1:0] b);
    return ($countones(a & b) > int'(N / 2)) ? {N{1'b1}} : {N{1'b0}};
  endfunction

  function automatic logic ref_err(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] p;
    p = a & b;
    return (p != {N{1'b0}}) && (p != {N{1'b1}});
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    w = {N{1'b1}};
    case ($urandom_range(0, 3))
      0: ;
      1: begin
        w[$urandom_range(0, N-1)] = 1'b0;
        if ($urandom_range(0, 1) == 1) w[$urandom_range(0, N-1)] = 1'b0;
      end
      2: w = N'($urandom);
      default: w = {N{1'b0}};
    endcase
    return w;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single transaction from an idle DUT; returns observed response and latency
  task automatic run_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] c, output logic err, output logic [ID_W-1:0] rid,
                        output logic [7:0] cnt, output logic [1:0] cnt_s, output int lat);
    int n;
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_valid = NREQ'(1) << id;
    rsp_ready = 1'b1;
    lat = -1;
    n = 0;
    @(negedge clk);
    while (req_ready[id] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n < 10) begin
      @(posedge clk);
      #1 req_valid = '0;
      n = 1;
      @(negedge clk);
      while (rsp_valid !== 1'b1 && n < 10) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      if (rsp_valid === 1'b1) lat = n;
    end
    c = rsp_c; err = rsp_err; rid = rsp_id; cnt = err_cnt; cnt_s = err_cnt_s;
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_c !== 5'b00000) begin failures++; $display("FAIL reset_rsp_c got=%b exp=00000", rsp_c); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [N-1:0] c; logic err; logic [ID_W-1:0] rid; logic [7:0] cnt; logic [1:0] cs; int lat;
    do_reset();
    run_op(0, 5'b11111, 5'b11111, c, err, rid, cnt, cs, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat); end
    checks++; if (c !== 5'b11111) begin failures++; $display("FAIL single_c got=%b exp=11111", c); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
    checks++; if (rid !== 1'b0) begin failures++; $display("FAIL single_id got=%0d exp=0", rid); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL single_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_correct();
    logic [N-1:0] c; logic err; logic [ID_W-1:0] rid; logic [7:0] cnt; logic [1:0] cs; int lat;
    logic [N-1:0] a [2];
    a[0] = 5'b11100;
    a[1] = 5'b00011;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      run_op(1, a[i], 5'b11111, c, err, rid, cnt, cs, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL correct_latency[%0d] got=%0d exp=2", i, lat); end
      checks++; if (c !== ref_c(a[i], 5'b11111)) begin failures++; $display("FAIL correct_c[%0d] got=%b exp=%b", i, c, ref_c(a[i], 5'b11111)); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL correct_err[%0d] got=%b exp=1", i, err); end
      checks++; if (rid !== 1'b1) begin failures++; $display("FAIL correct_id[%0d] got=%0d exp=1", i, rid); end
      checks++; if (cnt !== 8'(i + 1)) begin failures++; $display("FAIL correct_cnt[%0d] got=%0d exp=%0d", i, cnt, i + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a0, b0, a1, b1, ea, eb;
    logic [NREQ-1:0] exp_rr;
    logic exp_v;
    int eid;
    do_reset();
    a0 = rand_word(); b0 = rand_word(); a1 = rand_word(); b1 = rand_word();
    req_a = {a1, a0};
    req_b = {b1, b0};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_rr = (k % 2 == 0) ? (NREQ'(1) << ((k / 2) % 2)) : '0;
      exp_v  = (k >= 2) && (k % 2 == 0);
      checks++; if (req_ready !== exp_rr) begin failures++; $display("FAIL b2b_req_ready[%0d] got=%b exp=%b", k, req_ready, exp_rr); end
      checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL b2b_rsp_valid[%0d] got=%b exp=%b", k, rsp_valid, exp_v); end
      if (exp_v) begin
        eid = ((k / 2) - 1) % 2;
        ea = (eid == 1) ? a1 : a0;
        eb = (eid == 1) ? b1 : b0;
        checks++; if (rsp_id !== 1'(eid)) begin failures++; $display("FAIL b2b_rsp_id[%0d] got=%0d exp=%0d", k, rsp_id, eid); end
        checks++; if (rsp_c !== ref_c(ea, eb)) begin failures++; $display("FAIL b2b_rsp_c[%0d] got=%b exp=%b", k, rsp_c, ref_c(ea, eb)); end
        checks++; if (rsp_err !== ref_err(ea, eb)) begin failures++; $display("FAIL b2b_rsp_err[%0d] got=%b exp=%b", k, rsp_err, ref_err(ea, eb)); end
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req_a = {5'b00001, 5'b10111};
    req_b = {5'b11111, 5'b11111};
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL stall_first_grant got=%b exp=01", req_ready); end
    @(posedge clk);
    #1 req_valid = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL stall_exec_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_exec_valid got=%b exp=0", rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, rsp_valid); end
      checks++; if (rsp_c !== 5'b11111) begin failures++; $display("FAIL stall_c[%0d] got=%b exp=11111", k, rsp_c); end
      checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL stall_id[%0d] got=%0d exp=0", k, rsp_id); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=00", k, req_ready); end
      checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL stall_cnt[%0d] got=%0d exp=1", k, err_cnt); end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL stall_release_grant got=%b exp=10", req_ready); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_release_valid got=%b exp=1", rsp_valid); end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_second_exec got=%b exp=0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_second_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL stall_second_id got=%0d exp=1", rsp_id); end
    checks++; if (rsp_c !== 5'b00000) begin failures++; $display("FAIL stall_second_c got=%b exp=00000", rsp_c); end
    checks++; if (err_cnt !== 8'd2) begin failures++; $display("FAIL stall_second_cnt got=%0d exp=2", err_cnt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_exec();
    logic [N-1:0] c; logic err; logic [ID_W-1:0] rid; logic [7:0] cnt; logic [1:0] cs; int lat;
    do_reset();
    run_op(0, 5'b10111, 5'b11111, c, err, rid, cnt, cs, lat);
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL rstx_pre_cnt got=%0d exp=1", cnt); end
    req_a[0 +: N] = 5'b01111;
    req_b[0 +: N] = 5'b11111;
    req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rstx_grant got=%b exp=01", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstx_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_c !== 5'b00000) begin failures++; $display("FAIL rstx_c got=%b exp=00000", rsp_c); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL rstx_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rstx_err got=%b exp=0", rsp_err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rstx_cnt got=%0d exp=0", err_cnt); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rstx_ready got=%b exp=00", req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_a = {5'b11111, 5'b11111};
    req_b = {5'b11111, 5'b11111};
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstx_no_rsp got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rstx_next_grant got=%b exp=01", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic test_saturation();
    logic [N-1:0] c, a; logic err; logic [ID_W-1:0] rid; logic [7:0] cnt; logic [1:0] cs; int lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a = {N{1'b1}};
      a[$urandom_range(0, N-1)] = 1'b0;
      run_op(i % 2, a, 5'b11111, c, err, rid, cnt, cs, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL sat_latency[%0d] got=%0d exp=2", i, lat); end
      checks++; if (c !== 5'b11111 || err !== 1'b1) begin failures++; $display("FAIL sat_result[%0d] got=%b/%b exp=11111/1", i, c, err); end
      checks++; if (cnt !== 8'(i + 1)) begin failures++; $display("FAIL sat_cnt8[%0d] got=%0d exp=%0d", i, cnt, i + 1); end
      checks++; if (cs !== 2'((i + 1 > 3) ? 3 : i + 1)) begin failures++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, cs, (i + 1 > 3) ? 3 : i + 1); end
    end
  endtask

  typedef struct {
    int           id;
    logic [N-1:0] c;
    logic         err;
    int           total;
    int           gcyc;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [NREQ-1:0] pending, granted, exp_rr;
    int ptr, total, w;
    logic outstanding, exp_v, hs, exp_g;
    logic [N-1:0] wa, wb;
    do_reset();
    q.delete();
    pending = '0; granted = '0; ptr = 0; total = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1;
      pending = pending & ~granted;
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          req_a[i*N +: N] = rand_word();
          req_b[i*N +: N] = rand_word();
        end
      end
      req_valid = pending;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      outstanding = (q.size() > 0);
      exp_v = outstanding && (cyc - q[0].gcyc >= 2);
      checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v); end
      if (rsp_valid === 1'b1 && outstanding) begin
        e = q[0];
        checks++; if (rsp_id !== 1'(e.id)) begin failures++; $display("FAIL rnd_rsp_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, e.id); end
        checks++; if (rsp_c !== e.c) begin failures++; $display("FAIL rnd_rsp_c cyc=%0d got=%b exp=%b", cyc, rsp_c, e.c); end
        checks++; if (rsp_err !== e.err) begin failures++; $display("FAIL rnd_rsp_err cyc=%0d got=%b exp=%b", cyc, rsp_err, e.err); end
        checks++; if (err_cnt !== 8'((e.total > 255) ? 255 : e.total)) begin failures++; $display("FAIL rnd_err_cnt cyc=%0d got=%0d exp=%0d", cyc, err_cnt, e.total); end
        checks++; if (err_cnt_s !== 2'((e.total > 3) ? 3 : e.total)) begin failures++; $display("FAIL rnd_err_cnt_small cyc=%0d got=%0d exp=%0d", cyc, err_cnt_s, e.total); end
      end
      hs = (rsp_valid === 1'b1) && rsp_ready;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req_valid[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
      end
      exp_g  = (w >= 0) && (!outstanding || hs);
      exp_rr = exp_g ? (NREQ'(1) << w) : '0;
      checks++; if (req_ready !== exp_rr) begin failures++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rr); end
      if (hs && outstanding) void'(q.pop_front());
      if (exp_g) begin
        wa = req_a[w*N +: N];
        wb = req_b[w*N +: N];
        if (ref_err(wa, wb)) total++;
        e.id = w; e.c = ref_c(wa, wb); e.err = ref_err(wa, wb); e.total = total; e.gcyc = cyc;
        q.push_back(e);
        ptr = (w + 1) % NREQ;
      end
      granted = req_ready;
    end
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_correct();
    test_back_to_back();
    test_stall();
    test_reset_exec();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
